// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount as coins, largest denomination
// first, one coin per req/ack handshake with the hopper driver. If a hopper
// is empty it falls back to smaller coins. Whatever cannot be paid is
// reported as shortfall when the transaction ends.
//
// Optional feature: define COIN_TIMEOUT_EN to abort a coin request after
// TIMEOUT_CYCLES cycles without coin_ack. The abort raises fault and ends
// the transaction. With the macro undefined, fault is tied low.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, amount        one-cycle dispense request and its amount in cents
//   q_empty/d_empty/n_empty  hopper empty flags
//   coin_req, coin_sel   eject request and coin type (0=Q, 1=D, 2=N)
//   coin_ack             hopper has ejected the requested coin
//   busy, done           transaction in progress / one-cycle completion pulse
//   shortfall            cents not paid, held until the next accepted start
//   q/d/n_count          coins of each type paid this transaction
//   fault                hopper timeout occurred this transaction
module change_dispenser #(
    parameter int unsigned Q_VAL = 25,
    parameter int unsigned D_VAL = 10,
    parameter int unsigned N_VAL = 5
`ifdef COIN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       q_empty,
    input  logic       d_empty,
    input  logic       n_empty,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    input  logic       coin_ack,
    output logic       busy,
    output logic       done,
    output logic [7:0] shortfall,
    output logic [5:0] q_count,
    output logic [5:0] d_count,
    output logic [5:0] n_count,
    output logic       fault
);

    localparam int unsigned AW = 8;
    localparam int unsigned CW = 6;
    localparam logic [AW-1:0] Q_AMT = AW'(Q_VAL);
    localparam logic [AW-1:0] D_AMT = AW'(D_VAL);
    localparam logic [AW-1:0] N_AMT = AW'(N_VAL);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_REQ    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state, state_d;
    logic [AW-1:0]   remaining, remaining_d;
    logic            coin_req_d;
    logic [1:0]      coin_sel_d;
    logic            busy_d;
    logic            done_d;
    logic [AW-1:0]   shortfall_d;
    logic [CW-1:0]   q_count_d, d_count_d, n_count_d;
    logic            go_req;

`ifdef COIN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt, tcnt_d;
    logic          fault_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        coin_req_d  = coin_req;
        coin_sel_d  = coin_sel;
        busy_d      = busy;
        done_d      = 1'b0;
        shortfall_d = shortfall;
        q_count_d   = q_count;
        d_count_d   = d_count;
        n_count_d   = n_count;
        go_req      = 1'b0;
`ifdef COIN_TIMEOUT_EN
        tcnt_d      = tcnt;
        fault_d     = fault;
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    q_count_d   = '0;
                    d_count_d   = '0;
                    n_count_d   = '0;
                    shortfall_d = '0;
                    busy_d      = 1'b1;
`ifdef COIN_TIMEOUT_EN
                    fault_d     = 1'b0;
`endif
                    state_d     = S_SELECT;
                end
            end

            S_SELECT: begin
                // Largest coin that fits and whose hopper is not empty
                if (remaining >= Q_AMT && !q_empty) begin
                    coin_sel_d = 2'd0;
                    go_req     = 1'b1;
                end else if (remaining >= D_AMT && !d_empty) begin
                    coin_sel_d = 2'd1;
                    go_req     = 1'b1;
                end else if (remaining >= N_AMT && !n_empty) begin
                    coin_sel_d = 2'd2;
                    go_req     = 1'b1;
                end

                if (go_req) begin
                    coin_req_d = 1'b1;
`ifdef COIN_TIMEOUT_EN
                    tcnt_d     = '0;
`endif
                    state_d    = S_REQ;
                end else begin
                    // Shortfall and done are set on entry so both are valid in DONE
                    done_d      = 1'b1;
                    shortfall_d = remaining;
                    state_d     = S_DONE;
                end
            end

            S_REQ: begin
                if (coin_ack) begin
                    case (coin_sel)
                        2'd0: begin
                            remaining_d = remaining - Q_AMT;
                            q_count_d   = q_count + 6'd1;
                        end
                        2'd1: begin
                            remaining_d = remaining - D_AMT;
                            d_count_d   = d_count + 6'd1;
                        end
                        2'd2: begin
                            remaining_d = remaining - N_AMT;
                            n_count_d   = n_count + 6'd1;
                        end
                        default: ;
                    endcase
                    coin_req_d = 1'b0;
                    state_d    = S_SELECT;
                end
`ifdef COIN_TIMEOUT_EN
                else if (tcnt == T_LAST) begin
                    // Hopper stuck: give up, coin not counted
                    coin_req_d  = 1'b0;
                    fault_d     = 1'b1;
                    done_d      = 1'b1;
                    shortfall_d = remaining;
                    state_d     = S_DONE;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
`endif
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            coin_req  <= 1'b0;
            coin_sel  <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shortfall <= '0;
            q_count   <= '0;
            d_count   <= '0;
            n_count   <= '0;
        end else begin
            state     <= state_d;
            remaining <= remaining_d;
            coin_req  <= coin_req_d;
            coin_sel  <= coin_sel_d;
            busy      <= busy_d;
            done      <= done_d;
            shortfall <= shortfall_d;
            q_count   <= q_count_d;
            d_count   <= d_count_d;
            n_count   <= n_count_d;
        end
    end

`ifdef COIN_TIMEOUT_EN
    // Request timeout counter and fault flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt  <= '0;
            fault <= 1'b0;
        end else begin
            tcnt  <= tcnt_d;
            fault <= fault_d;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a table of directed transactions
// plus hand-written sequences for stalled acks, ignored starts, back-to-back
// starts, mid-transaction reset and (when enabled) the hopper timeout.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] amount;
    logic       q_empty, d_empty, n_empty;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       coin_ack;
    logic       busy, done;
    logic [7:0] shortfall;
    logic [5:0] q_count, d_count, n_count;
    logic       fault;

    int n_chk  = 0;
    int n_fail = 0;

    change_dispenser #(
        .Q_VAL(25),
        .D_VAL(10),
        .N_VAL(5)
`ifdef COIN_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .amount    (amount),
        .q_empty   (q_empty),
        .d_empty   (d_empty),
        .n_empty   (n_empty),
        .coin_req  (coin_req),
        .coin_sel  (coin_sel),
        .coin_ack  (coin_ack),
        .busy      (busy),
        .done      (done),
        .shortfall (shortfall),
        .q_count   (q_count),
        .d_count   (d_count),
        .n_count   (n_count),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  amt;
        logic        qe, de, ne;
        int          coins;
        logic [15:0] seq;   // last 8 coin_sel values, oldest in the high bits
        int          q, d, n;
        int          sf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at the negedge right after start was accepted (cycle 1 = SELECT).
    // Acts as the hopper: acks each request after ack_delay stalled cycles.
    task automatic wait_txn(input int ack_delay, output int n_coins,
                            output logic [15:0] seq, output int done_cycle,
                            output int req_cycles);
        int wc;
        int cyc;
        logic [15:0] s;
        n_coins = 0; s = '0; done_cycle = -1; req_cycles = 0; wc = 0; cyc = 1;
        while (cyc <= 400) begin
            if (done) begin
                done_cycle = cyc;
                break;
            end
            if (coin_req) begin
                req_cycles++;
                if (wc == ack_delay) begin
                    coin_ack = 1'b1;
                    n_coins++;
                    s = {s[13:0], coin_sel};
                    wc = 0;
                end else begin
                    coin_ack = 1'b0;
                    wc++;
                end
            end else begin
                coin_ack = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        coin_ack = 1'b0;
        seq = s;
    endtask

    initial begin
        int          nc, dc, rc;
        logic [15:0] sq;

        vecs[0] = '{8'd40,  1'b0, 1'b0, 1'b0, 3,  16'h0006, 1,  1, 1,  0};
        vecs[1] = '{8'd30,  1'b1, 1'b0, 1'b0, 3,  16'h0015, 0,  3, 0,  0};
        vecs[2] = '{8'd17,  1'b0, 1'b0, 1'b0, 2,  16'h0006, 0,  1, 1,  2};
        vecs[3] = '{8'd0,   1'b0, 1'b0, 1'b0, 0,  16'h0000, 0,  0, 0,  0};
        vecs[4] = '{8'd3,   1'b0, 1'b0, 1'b0, 0,  16'h0000, 0,  0, 0,  3};
        vecs[5] = '{8'd60,  1'b1, 1'b1, 1'b0, 12, 16'hAAAA, 0,  0, 12, 0};
        vecs[6] = '{8'd255, 1'b0, 1'b0, 1'b0, 11, 16'h0002, 10, 0, 1,  0};
        vecs[7] = '{8'd45,  1'b0, 1'b1, 1'b0, 5,  16'h00AA, 1,  0, 4,  0};
        vecs[8] = '{8'd35,  1'b1, 1'b1, 1'b1, 0,  16'h0000, 0,  0, 0,  35};

        rst_n = 1'b0; start = 1'b0; amount = '0; coin_ack = 1'b0;
        q_empty = 1'b0; d_empty = 1'b0; n_empty = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({coin_req, coin_sel, busy, done, shortfall,
                                  q_count, d_count, n_count, fault}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven transactions, hopper acks immediately
        for (int i = 0; i < 9; i++) begin
            q_empty = vecs[i].qe; d_empty = vecs[i].de; n_empty = vecs[i].ne;
            amount = vecs[i].amt; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_txn(0, nc, sq, dc, rc);
            chk($sformatf("v%0d_coins", i), 32'(nc), 32'(vecs[i].coins));
            chk($sformatf("v%0d_seq", i), 32'(sq), 32'(vecs[i].seq));
            chk($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(2 + 2 * vecs[i].coins));
            chk($sformatf("v%0d_shortfall", i), 32'(shortfall), 32'(vecs[i].sf));
            chk($sformatf("v%0d_q_count", i), 32'(q_count), 32'(vecs[i].q));
            chk($sformatf("v%0d_d_count", i), 32'(d_count), 32'(vecs[i].d));
            chk($sformatf("v%0d_n_count", i), 32'(n_count), 32'(vecs[i].n));
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_shortfall_hold", i), 32'(shortfall), 32'(vecs[i].sf));
        end
        chk("fault_idle", 32'(fault), 32'd0);

        // Stalled ack: request must stay stable; a start during REQ is ignored
        q_empty = 1'b0; d_empty = 1'b0; n_empty = 1'b0;
        amount = 8'd25; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_req_sel", i), 32'({coin_req, coin_sel}), 32'h4);
            if (i == 1) begin
                start = 1'b1; amount = 8'd10;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        chk("stall_req_drop", 32'(coin_req), 32'd0);
        @(negedge clk);
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_q_count", 32'(q_count), 32'd1);
        chk("stall_shortfall", 32'(shortfall), 32'd0);

        // Start in the done cycle is ignored, accepted one cycle later
        amount = 8'd5; start = 1'b1;
        @(negedge clk);
        chk("b2b_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accepted", 32'(busy), 32'd1);
        wait_txn(0, nc, sq, dc, rc);
        chk("b2b_coins", 32'(nc), 32'd1);
        chk("b2b_seq", 32'(sq), 32'd2);
        chk("b2b_done_cycle", 32'(dc), 32'd4);
        chk("b2b_counts", 32'({q_count, d_count, n_count}), 32'({6'd0, 6'd0, 6'd1}));
        @(negedge clk);

        // Reset in the middle of a transaction
        amount = 8'd40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_pre_req", 32'(coin_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", 32'({coin_req, coin_sel, busy, done, shortfall,
                                    q_count, d_count, n_count, fault}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_stays_idle", 32'({coin_req, busy}), 32'd0);

`ifdef COIN_TIMEOUT_EN
        // Hopper never acks: request dropped after 8 cycles with fault
        amount = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_txn(1000, nc, sq, dc, rc);
        chk("to_req_cycles", 32'(rc), 32'd8);
        chk("to_done_cycle", 32'(dc), 32'd10);
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_shortfall", 32'(shortfall), 32'd10);
        chk("to_d_count", 32'(d_count), 32'd0);
        @(negedge clk);
        chk("to_done_pulse", 32'({done, busy}), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Pays out the change amount (in cents) computed at purchase time as a sequence of physical coins. The sequence is largest-denomination-first, one coin at a time, using a req/ack handshake to the coin hopper driver. If a hopper is empty, the block falls back to smaller coins. Any amount that cannot be paid is reported as shortfall to the top-level vending FSM.

Parameters:
Q_VAL, 25, quarter value in cents
D_VAL, 10, dime value in cents
N_VAL, 5, nickel value in cents
TIMEOUT_CYCLES, 1000, max cycles to wait for coin_ack (used only with timeout feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to dispense amount
amount  in  8  change to pay, cents, sampled when start accepted
q_empty  in  1  quarter hopper empty
d_empty  in  1  dime hopper empty
n_empty  in  1  nickel hopper empty
coin_req  out  1  request hopper eject one coin
coin_sel  out  2  coin type: 0=quarter 1=dime 2=nickel (3 unused)
coin_ack  in  1  hopper has ejected the requested coin
busy  out  1  high from start acceptance until DONE exits
done  out  1  one-cycle completion pulse
shortfall  out  8  cents not paid; valid from done until next accepted start
q_count  out  6  quarters paid this transaction
d_count  out  6  dimes paid this transaction
n_count  out  6  nickels paid this transaction
fault  out  1  hopper timeout occurred this transaction (0 without feature)

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0; internal remaining=0. Reset mid-transaction aborts immediately. No further coin_req is issued. Counts are cleared.
- States: IDLE, SELECT, REQ, DONE.
- IDLE: on start=1, latch amount into remaining, clear counts/shortfall/fault, set busy, go to SELECT. start is ignored in all other states.
- SELECT (1 cycle), priority order:
  - remaining>=Q_VAL and !q_empty -> sel=0, go to REQ.
  - else remaining>=D_VAL and !d_empty -> sel=1, go to REQ.
  - else remaining>=N_VAL and !n_empty -> sel=2, go to REQ.
  - else go to DONE (covers remaining=0).
- REQ:
  - coin_req=1 and coin_sel stable for the whole state. Empty flags are not re-sampled; the coin choice is committed.
  - On coin_ack=1: remaining -= coin value; increment the matching count; coin_req deasserts the next cycle; go to SELECT.
  - coin_ack outside REQ is ignored.
- DONE (1 cycle): shortfall<=remaining, done=1, busy<=0, go to IDLE. shortfall and counts hold until the next accepted start.
- Latency: start sampled at edge k -> SELECT during k+1 -> coin_req high from k+2. After an ack at edge j, the next coin_req is high from j+2. For amount=0, done is high at cycle k+2.
- Arithmetic: 8-bit unsigned subtraction. Underflow is impossible because of the >= checks. Counts are 6-bit: the max 255/5=51 fits.
- Amounts not a multiple of N_VAL leave a residue in shortfall (e.g. 3 cents).
- Back-to-back: start in the same cycle done is high is ignored. start is accepted from the following cycle onward.

Optional Feature:
COIN_TIMEOUT_EN:
- Defined:
  - A cycle counter runs in REQ and is reset on entry to REQ.
  - If TIMEOUT_CYCLES elapse with no coin_ack, coin_req drops, fault<=1, and the FSM goes to DONE with shortfall=remaining (the coin is not counted).
  - An ack arriving on the same cycle as the timeout counts as a normal ack.
- Undefined: REQ waits indefinitely; fault is tied to 0 and no counter logic exists.

Test Plan:
- amount=40, no hoppers empty -> coins quarter, dime, nickel in order; q/d/n_count=1/1/1; done pulse; shortfall=0; busy low after done.
- amount=30, q_empty=1 -> three dime requests (coin_sel=1); d_count=3; shortfall=0.
- amount=17 -> one dime, one nickel; shortfall=2.
- amount=0 -> no coin_req; done high 2 cycles after start; shortfall=0; counts=0.
- amount=25, hold coin_ack low 5 cycles -> coin_req and coin_sel=0 stable all 5 cycles. A start pulse during REQ is ignored. Ack -> done, q_count=1. Then assert rst_n=0 mid-second-transaction -> all outputs 0 next cycle.
- With COIN_TIMEOUT_EN and TIMEOUT_CYCLES=8, amount=10, never ack -> coin_req drops after 8 cycles; fault=1; shortfall=10; done pulse.
